// File: rtl/queue_pkg.sv
// Shared parameters and pointer-wrap helper for the RAM-backed queue.
package queue_pkg;

    localparam int unsigned DEPTH_DEFAULT = 3;
    localparam int unsigned WIDTH_DEFAULT = 78;

    // Explicit wrap: depth need not be a power of two.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/ram_3x78.sv
// Two-port memory: one clocked write port, one combinational read port.
module ram_3x78
    import queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             R0_clk,
    input  logic [AW-1:0]    R0_addr,
    input  logic             R0_en,
    output logic [WIDTH-1:0] R0_data,
    input  logic             W0_clk,
    input  logic [AW-1:0]    W0_addr,
    input  logic             W0_en,
    input  logic [WIDTH-1:0] W0_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read port is asynchronous; its clock exists only for interface symmetry.
    logic unused_r0_clk;
    assign unused_r0_clk = R0_clk;

    always_ff @(posedge W0_clk) begin
        if (W0_en) begin
            mem_q[W0_addr] <= W0_data;
        end
    end

    assign R0_data = R0_en ? mem_q[R0_addr] : '0;

endmodule

// File: rtl/queue_ctrl_3x78.sv
// Ready/valid FIFO controller driving both ports of a two-port RAM.
module queue_ctrl_3x78
    import queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic [AW:0]      count
);

    logic [AW-1:0] enq_ptr_q, enq_ptr_d;
    logic [AW-1:0] deq_ptr_q, deq_ptr_d;
    logic          maybe_full_q, maybe_full_d;

    logic          ptr_match, empty, full;
    logic          do_enq, do_deq;
    logic [AW:0]   enq_ext, deq_ext;

    logic          ram_w_en;
    logic [AW-1:0] ram_w_addr;
    logic          ram_r_en;
    logic [AW-1:0] ram_r_addr;

    assign ptr_match = (enq_ptr_q == deq_ptr_q);
    assign empty     = ptr_match & ~maybe_full_q;
    assign full      = ptr_match & maybe_full_q;

    // Flags depend only on state, so there is no flow-through between ports.
    assign enq_ready = ~full;
    assign deq_valid = ~empty;
    assign do_enq    = enq_valid & enq_ready;
    assign do_deq    = deq_valid & deq_ready;

    always_comb begin
        enq_ptr_d    = enq_ptr_q;
        deq_ptr_d    = deq_ptr_q;
        maybe_full_d = maybe_full_q;
        if (do_enq) begin
            enq_ptr_d = AW'(ptr_inc(32'(enq_ptr_q), DEPTH));
        end
        if (do_deq) begin
            deq_ptr_d = AW'(ptr_inc(32'(deq_ptr_q), DEPTH));
        end
        if (do_enq != do_deq) begin
            maybe_full_d = do_enq;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enq_ptr_q    <= '0;
            deq_ptr_q    <= '0;
            maybe_full_q <= 1'b0;
        end else begin
            enq_ptr_q    <= enq_ptr_d;
            deq_ptr_q    <= deq_ptr_d;
            maybe_full_q <= maybe_full_d;
        end
    end

    assign enq_ext = {1'b0, enq_ptr_q};
    assign deq_ext = {1'b0, deq_ptr_q};

    always_comb begin
        count = '0;
        if (ptr_match) begin
            count = maybe_full_q ? (AW+1)'(DEPTH) : '0;
        end else if (enq_ptr_q > deq_ptr_q) begin
            count = enq_ext - deq_ext;
        end else begin
            count = (AW+1)'(DEPTH) - deq_ext + enq_ext;
        end
    end

    assign ram_w_en   = do_enq;
    assign ram_w_addr = enq_ptr_q;
    assign ram_r_en   = ~empty;
    assign ram_r_addr = deq_ptr_q;

    ram_3x78 #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .R0_clk  (clock),
        .R0_addr (ram_r_addr),
        .R0_en   (ram_r_en),
        .R0_data (deq_bits),
        .W0_clk  (clock),
        .W0_addr (ram_w_addr),
        .W0_en   (ram_w_en),
        .W0_data (enq_bits)
    );

endmodule

// File: doc/queue_ctrl_3x78.md
Name: queue_ctrl_3x78

Overview:
- Ready/valid FIFO controller that owns both ports of a 3-entry x 78-bit two-port RAM (one write port, one combinational read port).
- Drives the RAM's write address, enable and data from the enqueue side.
- Drives the RAM's read address and enable for the dequeue side.
- Used as the storage-backed queue in utility buffering paths; the RAM itself is the sub-module.

Parameters:
- DEPTH, 3, number of entries; any value >= 2, not required to be a power of two.
- WIDTH, 78, payload width in bits.
- AW, 2, address width; equals clog2(DEPTH).

Ports:
- clock  in  1  sole clock; all state and the RAM write port use it.
- reset_n  in  1  asynchronous, active-low reset.
- enq_valid  in  1  producer has data.
- enq_ready  out  1  queue can accept; equals !full.
- enq_bits  in  WIDTH  payload.
- deq_valid  out  1  queue holds data; equals !empty.
- deq_ready  in  1  consumer accepts.
- deq_bits  out  WIDTH  head payload; combinational from the RAM read port.
- count  out  AW+1  occupancy, 0..DEPTH.

Behaviour:
- State: enq_ptr [AW-1:0], deq_ptr [AW-1:0], maybe_full (1 bit). Flops reset asynchronously on reset_n low.
- Reset values: enq_ptr=0, deq_ptr=0, maybe_full=0.
- Outputs during and after reset: enq_ready=1, deq_valid=0, count=0.
- Derived flags:
  - ptr_match = (enq_ptr==deq_ptr)
  - empty = ptr_match & !maybe_full
  - full = ptr_match & maybe_full
- Handshakes: do_enq = enq_valid & enq_ready; do_deq = deq_valid & deq_ready. No combinational path from enq_valid to deq_valid, or from deq_ready to enq_ready (no flow-through, no pipe bypass).
- RAM write port:
  - W0_addr = enq_ptr, W0_en = do_enq, W0_data = enq_bits.
  - The write lands at the rising edge of clock.
- RAM read port:
  - R0_addr = deq_ptr, R0_en = !empty.
  - deq_bits = R0_data. deq_bits is don't-care (X allowed) while deq_valid=0; the bench must not check it then.
- Latency: data enqueued in cycle N is visible on deq_bits with deq_valid=1 in cycle N+1. Minimum occupancy latency is 1 cycle.
- Pointer advance: on do_enq, enq_ptr <= (enq_ptr==DEPTH-1) ? 0 : enq_ptr+1. deq_ptr advances the same way on do_deq. Explicit wrap is mandatory; there is no natural 2-bit overflow for DEPTH=3, so address 3 must never be driven.
- maybe_full update: if do_enq != do_deq, maybe_full <= do_enq; otherwise it holds.
- count:
  - ptr_match: count = maybe_full ? DEPTH : 0.
  - enq_ptr > deq_ptr: count = enq_ptr - deq_ptr.
  - otherwise: count = DEPTH - deq_ptr + enq_ptr.
  - Computed at AW+1 bits.
- Boundary conditions:
  - Full: enq_ready=0; enq_valid is ignored and no write occurs.
  - Full with deq_ready=1: dequeue only. enq_ready stays 0 in that cycle, so there is no same-address read/write hazard.
  - Empty: deq_valid=0; deq_ready is ignored and no pointer moves.
  - Simultaneous enq and deq with 0 < count < DEPTH: both pointers advance, maybe_full unchanged, count unchanged.
  - Reset mid-operation: pointers and flag clear immediately (asynchronous assert) and the queue reads empty. RAM contents are not cleared and are unobservable until rewritten.
  - Reset deassertion is expected to be synchronized externally.

Decomposition:
- Shared package queue_pkg: localparams DEPTH_DEFAULT=3, WIDTH_DEFAULT=78; function ptr_inc(ptr, depth) implementing the wrap.
- One sub-module: ram_3x78, the existing two-port memory, instantiated once with R0_clk=W0_clk=clock.
- All control logic (pointers, flags, count) lives in queue_ctrl_3x78.

Test Plan:
- Reset then idle: hold reset_n=0 for 3 cycles, release. Expect enq_ready=1, deq_valid=0, count=0; no W0_en pulses.
- Fill to full: enqueue 78'h1, 78'h2, 78'h3 on consecutive cycles with deq_ready=0. Expect count 1,2,3; enq_ready=0 after the third; a 4th enq_valid with 78'hDEAD is dropped (count stays 3).
- Drain and wrap:
  - From full, deq_ready=1 for 3 cycles. Expect deq_bits 1,2,3 in order, then deq_valid=0.
  - Enqueue 78'hA, 78'hB. They write at addresses 0 and 1 (enq_ptr wrapped 2->0).
  - Dequeue returns A, B. deq_ptr never equals 3.
- Simultaneous streaming: with count=1 holding 78'h5, drive enq and deq every cycle for 10 cycles with values 6..15. count stays 1 throughout; deq_bits sequence is 5,6,...,14.
- Full with dequeue: at count=3 assert deq_ready=1 and enq_valid=1. Expect one dequeue only, count=2. In the next cycle enq_ready=1 and the enqueue is accepted.
- Reset mid-operation: at count=2, pulse reset_n low asynchronously mid-cycle. Expect deq_valid=0 and count=0 immediately. After release, enqueue 78'h77 and dequeue 78'h77 (stale entries are not observed).
